// File: rtl/cpu19_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu19_pkg : shared widths, requester ids and writeback packet type    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cpu19_pkg;

  localparam int XLEN = 19;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);
  localparam int NREQ = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MUL = 2;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_pkt_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] a);
    reg_onehot = NREG'(1) << a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb_sched_if : requester, writeback, issue and scoreboard bus  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface regfile_wb_sched_if;

  localparam int NREQ = cpu19_pkg::NREQ;
  localparam int XLEN = cpu19_pkg::XLEN;
  localparam int NREG = cpu19_pkg::NREG;
  localparam int AW   = cpu19_pkg::AW;

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*AW-1:0]   req_rd_addr_i;
  logic [NREQ*XLEN-1:0] req_data_i;

  logic                 wb_wr_en_o;
  logic [AW-1:0]        wb_rd_addr_o;
  logic [XLEN-1:0]      wb_wr_data_o;

  logic                 iss_valid_i;
  logic [AW-1:0]        iss_rd_addr_i;
  logic [AW-1:0]        iss_rs1_addr_i;
  logic [AW-1:0]        iss_rs2_addr_i;

  logic                 hazard_o;
  logic [NREG-1:0]      busy_o;
  logic                 wb_err_o;

  modport master (
    output req_valid_i, req_rd_addr_i, req_data_i,
    output iss_valid_i, iss_rd_addr_i, iss_rs1_addr_i, iss_rs2_addr_i,
    input  req_ready_o, wb_wr_en_o, wb_rd_addr_o, wb_wr_data_o,
    input  hazard_o, busy_o, wb_err_o
  );

  modport slave (
    input  req_valid_i, req_rd_addr_i, req_data_i,
    input  iss_valid_i, iss_rd_addr_i, iss_rs1_addr_i, iss_rs2_addr_i,
    output req_ready_o, wb_wr_en_o, wb_rd_addr_o, wb_wr_data_o,
    output hazard_o, busy_o, wb_err_o
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant, pointer moves on advance      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] C_PTR_RST = PW'(NREQ - 1);

  logic [PW-1:0]   r_last;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_grant;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_grant = '0;
    w_idx   = r_last;
    for (int i = NREQ; i >= 1; i--) begin
      if (i_req[(int'(r_last) + i) % NREQ]) begin
        w_grant = '0;
        w_grant[(int'(r_last) + i) % NREQ] = 1'b1;
        w_idx = PW'((int'(r_last) + i) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= C_PTR_RST;
    end else if (i_advance) begin
      r_last <= w_idx;
    end
  end

  assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb_sched : shared regfile write-port scheduler + scoreboard   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module regfile_wb_sched
  import cpu19_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  regfile_wb_sched_if.slave  bus
);

  logic [NREQ-1:0] w_grant;
  logic            w_accept;
  wb_pkt_t         w_sel;

  logic            r_wb_en;
  wb_pkt_t         r_wb;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_set;
  logic [NREG-1:0] w_busy_clr;
  logic [NREG-1:0] w_busy_nxt;

  logic            r_err;
  logic            w_clr_pending;
  logic            w_err_evt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (bus.req_valid_i),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  assign bus.req_ready_o = w_grant;
  assign w_accept        = |(bus.req_valid_i & w_grant);

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel.rd   = bus.req_rd_addr_i[k*AW +: AW];
        w_sel.data = bus.req_data_i[k*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 still consume the handshake but never reach the regfile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_en <= 1'b0;
      r_wb    <= '0;
    end else if (w_accept) begin
      r_wb_en <= (w_sel.rd != '0);
      r_wb    <= w_sel;
    end else begin
      r_wb_en <= 1'b0;
    end
  end

  assign w_busy_clr = r_wb_en ? reg_onehot(r_wb.rd) : '0;
  assign w_busy_set = (bus.iss_valid_i && (bus.iss_rd_addr_i != '0))
                      ? reg_onehot(bus.iss_rd_addr_i) : '0;
  assign w_busy_nxt = ((r_busy & ~w_busy_clr) | w_busy_set) & ~NREG'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign w_clr_pending = r_wb_en && (r_wb.rd == w_sel.rd);
  assign w_err_evt     = w_accept && (w_sel.rd != '0) &&
                         !r_busy[w_sel.rd] && !w_clr_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign bus.wb_wr_en_o   = r_wb_en;
  assign bus.wb_rd_addr_o = r_wb.rd;
  assign bus.wb_wr_data_o = r_wb.data;
  assign bus.busy_o       = r_busy;
  assign bus.wb_err_o     = r_err;
  assign bus.hazard_o     = r_busy[bus.iss_rs1_addr_i] |
                            r_busy[bus.iss_rs2_addr_i] |
                            r_busy[bus.iss_rd_addr_i];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_wb_sched : directed stimulus plus cycle scoreboard         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_regfile_wb_sched;
  import cpu19_pkg::*;

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  regfile_wb_sched_if u_if ();

  regfile_wb_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference model, evaluated mid-cycle on the falling edge.
  exp_t          q[$];
  logic [1:0]    m_last;
  logic [NREG-1:0] m_busy;
  logic          m_err;
  logic          m_en;
  logic [AW-1:0] m_rd;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_last = 2'd2;
      m_busy = '0;
      m_err  = 1'b0;
      m_en   = 1'b0;
      m_rd   = '0;
    end else begin
      exp_t            e;
      logic [NREQ-1:0] g;
      int              gk;
      logic [AW-1:0]   grd;
      logic [NREG-1:0] nb;
      m_en = 1'b0;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_wr_en", u_if.wb_wr_en_o, e.en);
        check("sb_addr", u_if.wb_rd_addr_o, e.rd);
        check("sb_data", u_if.wb_wr_data_o, e.data);
        m_en = e.en;
        m_rd = e.rd;
      end else begin
        check("sb_idle_wr_en", u_if.wb_wr_en_o, 1'b0);
      end
      check("sb_busy", u_if.busy_o, m_busy);
      check("sb_err", u_if.wb_err_o, m_err);
      check("sb_hazard", u_if.hazard_o,
            m_busy[u_if.iss_rs1_addr_i] | m_busy[u_if.iss_rs2_addr_i] |
            m_busy[u_if.iss_rd_addr_i]);
      g  = '0;
      gk = -1;
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (int'(m_last) + i) % NREQ;
        if (gk < 0 && u_if.req_valid_i[k]) begin
          gk = k;
          g[k] = 1'b1;
        end
      end
      check("sb_ready", u_if.req_ready_o, g);
      nb = m_busy;
      if (m_en) nb[m_rd] = 1'b0;
      if (gk >= 0) begin
        grd = u_if.req_rd_addr_i[gk*AW +: AW];
        q.push_back({grd != '0, grd, u_if.req_data_i[gk*XLEN +: XLEN]});
        if (grd != '0 && !m_busy[grd] && !(m_en && m_rd == grd)) m_err = 1'b1;
        m_last = 2'(gk);
      end
      if (u_if.iss_valid_i && u_if.iss_rd_addr_i != '0) nb[u_if.iss_rd_addr_i] = 1'b1;
      nb[0]  = 1'b0;
      m_busy = nb;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    u_if.req_valid_i[k]              = 1'b1;
    u_if.req_rd_addr_i[k*AW +: AW]   = rd;
    u_if.req_data_i[k*XLEN +: XLEN]  = d;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rd);
    u_if.iss_valid_i   = v;
    u_if.iss_rd_addr_i = rd;
  endtask

  logic [2:0] rr_exp [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset = 1'b1;
    u_if.req_valid_i    = '0;
    u_if.req_rd_addr_i  = '0;
    u_if.req_data_i     = '0;
    u_if.iss_valid_i    = 1'b0;
    u_if.iss_rd_addr_i  = '0;
    u_if.iss_rs1_addr_i = '0;
    u_if.iss_rs2_addr_i = '0;
    repeat (2) step();
    reset = 1'b0;
    check("rst_wr_en", u_if.wb_wr_en_o, 1'b0);
    check("rst_addr", u_if.wb_rd_addr_o, 3'd0);
    check("rst_data", u_if.wb_wr_data_o, 19'd0);
    check("rst_busy", u_if.busy_o, 8'h00);
    check("rst_err", u_if.wb_err_o, 1'b0);

    // Requester 2 alone, writing x0.
    set_req(2, 3'd0, 19'h5_5555);
    #1;
    check("x0_ready", u_if.req_ready_o, 3'b100);
    step();
    u_if.req_valid_i = '0;
    check("x0_wr_en", u_if.wb_wr_en_o, 1'b0);
    check("x0_busy", u_if.busy_o, 8'h00);
    step();
    check("x0_err", u_if.wb_err_o, 1'b0);

    // Issue rd=3 then ALU writes it back.
    issue(1'b1, 3'd3);
    step();
    issue(1'b0, 3'd0);
    check("iss3_busy", u_if.busy_o, 8'h08);
    set_req(REQ_ALU, 3'd3, 19'h7_1234);
    step();
    u_if.req_valid_i = '0;
    check("wb3_wr_en", u_if.wb_wr_en_o, 1'b1);
    check("wb3_addr", u_if.wb_rd_addr_o, 3'd3);
    check("wb3_data", u_if.wb_wr_data_o, 19'h7_1234);
    check("wb3_busy_still", u_if.busy_o, 8'h08);
    step();
    check("wb3_busy_clr", u_if.busy_o, 8'h00);
    check("wb3_wr_en_off", u_if.wb_wr_en_o, 1'b0);
    check("wb3_addr_hold", u_if.wb_rd_addr_o, 3'd3);
    check("wb3_data_hold", u_if.wb_wr_data_o, 19'h7_1234);

    // Re-issue rd=5 in the same cycle its writeback lands: set wins.
    issue(1'b1, 3'd5);
    step();
    issue(1'b0, 3'd0);
    set_req(REQ_LSU, 3'd5, 19'h1_2345);
    #1;
    check("lsu_ready", u_if.req_ready_o, 3'b010);
    step();
    u_if.req_valid_i = '0;
    issue(1'b1, 3'd5);
    check("wb5_wr_en", u_if.wb_wr_en_o, 1'b1);
    check("wb5_addr", u_if.wb_rd_addr_o, 3'd5);
    step();
    issue(1'b0, 3'd0);
    check("set_wins_busy", u_if.busy_o, 8'h20);
    u_if.iss_rs2_addr_i = 3'd5;
    #1;
    check("hazard_rs2", u_if.hazard_o, 1'b1);
    u_if.iss_rs2_addr_i = 3'd4;
    #1;
    check("no_hazard_rs2", u_if.hazard_o, 1'b0);
    u_if.iss_rs2_addr_i = 3'd0;
    set_req(REQ_MUL, 3'd5, 19'h0_0abc);
    step();
    u_if.req_valid_i = '0;
    step();
    check("wb5b_busy_clr", u_if.busy_o, 8'h00);
    check("wb5b_err", u_if.wb_err_o, 1'b0);

    // Asynchronous reset with a write in flight.
    issue(1'b1, 3'd7);
    step();
    issue(1'b0, 3'd0);
    set_req(REQ_ALU, 3'd7, 19'h0_0003);
    step();
    u_if.req_valid_i = '0;
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", u_if.busy_o, 8'h00);
    check("async_wr_en", u_if.wb_wr_en_o, 1'b0);
    check("async_data", u_if.wb_wr_data_o, 19'd0);
    step();
    reset = 1'b0;

    // All requesters continuously valid from reset.
    for (int k = 0; k < NREQ; k++) set_req(k, 3'd0, 19'(32'h100 + k));
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), u_if.req_ready_o, rr_exp[i]);
      step();
    end
    u_if.req_valid_i = '0;
    step();

    // Writeback to a register nobody issued.
    set_req(REQ_ALU, 3'd6, 19'h2_0006);
    #1;
    check("err_pre", u_if.wb_err_o, 1'b0);
    step();
    u_if.req_valid_i = '0;
    check("err_set", u_if.wb_err_o, 1'b1);
    repeat (3) step();
    check("err_sticky", u_if.wb_err_o, 1'b1);
    reset = 1'b1;
    #1;
    check("err_reset", u_if.wb_err_o, 1'b0);
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Writeback scheduler and register scoreboard for the 19-bit CPU. It shares the register file's single write port between the ALU, load/store and multiply units using round-robin arbitration. It also tracks in-flight destination registers, so the issue stage can stall on RAW/WAW hazards. It sits between the execution units and the register file write port (wr_en/rd_addr/wr_data).

## Interface
- NREQ, 3, number of writeback requesters (0 = ALU, 1 = LSU, 2 = MUL)
- XLEN, 19, data width
- NREG, 8, architectural registers; AW = $clog2(NREG) = 3
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  NREQ  requester has a result
- req_ready_o  out  NREQ  one-hot grant; handshake completes when valid & ready
- req_rd_addr_i  in  NREQ*AW  destination per requester, packed, requester k at [k*AW +: AW]
- req_data_i  in  NREQ*XLEN  result per requester, packed likewise
- wb_wr_en_o  out  1  to regfile wr_en
- wb_rd_addr_o  out  AW  to regfile rd_addr
- wb_wr_data_o  out  XLEN  to regfile wr_data
- iss_valid_i  in  1  issue stage dispatches an instruction this cycle
- iss_rd_addr_i  in  AW  its destination (x0 = no write)
- iss_rs1_addr_i, iss_rs2_addr_i  in  AW  its sources
- hazard_o  out  1  busy[rs1] | busy[rs2] | busy[rd]; combinational
- busy_o  out  NREG  scoreboard bits
- wb_err_o  out  1  sticky protocol error

## Operation
- Arbitration: round-robin among asserted req_valid_i. Search starts at (last_grant+1) mod NREQ. req_ready_o is combinational from req_valid_i and the pointer. Exactly one bit is set when any valid is high, zero otherwise.
- The pointer updates to the granted index only on a completed handshake.
- Accepted request: the output register loads wb_rd_addr_o/wb_wr_data_o. wb_wr_en_o = 1 if rd != 0, else 0 (write to x0 dropped, handshake still completes).
- No accepted request: wb_wr_en_o = 0 next cycle. Address and data hold their previous values.
- The regfile always accepts, so there is no backpressure on the output register.
- Scoreboard set: iss_valid_i & iss_rd_addr_i != 0 sets busy[rd] at the clock edge.
- Scoreboard clear: wb_wr_en_o = 1 clears busy[wb_rd_addr_o] at the same edge the regfile writes.
- Simultaneous set and clear of the same register: set wins.
- busy[0] is constantly 0.
- The issue stage must assert iss_valid_i only when hazard_o = 0. The block does not block an issue that violates this; it sets busy regardless.
- wb_err_o is set when an accepted request has rd != 0 and busy[rd] = 0, with no clear of that register pending in the output stage. It is cleared only by reset.

## Timing
- Reset values:
  - req_ready_o follows valids immediately; the pointer resets to NREQ-1, so requester 0 wins first.
  - wb_wr_en_o = 0, wb_rd_addr_o = 0, wb_wr_data_o = 0.
  - busy_o = 0, wb_err_o = 0.
- Latency: handshake in cycle N; wb_* valid in cycle N+1; regfile and busy update at the end of N+1.
- A dependent instruction sees hazard_o = 0 in cycle N+2 and reads the new value from the regfile.
- Throughput: one writeback per cycle. With all requesters continuously valid, grants rotate 0,1,2,0,… and each requester gets exactly one grant in any 3 consecutive cycles.
- Reset mid-operation clears the scoreboard and output stage asynchronously. In-flight results are lost; the pipeline is flushed by the same reset.

## Structure
- Shared package cpu19_pkg holds:
  - XLEN = 19, NREG = 8, AW = 3, NREQ = 3
  - requester index constants REQ_ALU = 0, REQ_LSU = 1, REQ_MUL = 2
  - a typedef for a writeback packet struct {rd, data}
- One sub-module, rr_arbiter, parameterised on NREQ. Inputs: req and advance. Outputs: one-hot grant; it holds the pointer register.
- The scoreboard and output register live in regfile_wb_sched.

## Test plan
- Reset → wb_wr_en_o = 0, busy_o = 8'h00, wb_err_o = 0; a single valid on requester 2 gets req_ready_o = 3'b100 in the same cycle.
- Issue rd = 3 (busy_o = 8'h08), then ALU request rd = 3, data = 19'h7_1234 → wb_wr_en_o = 1, addr = 3, data = 19'h71234 one cycle later, busy_o = 0 the cycle after.
- All three valid for 6 cycles after reset → grants 001, 010, 100, 001, 010, 100.
- Request with rd = 0, data = 19'h5_5555 → ready asserted, wb_wr_en_o stays 0, busy unchanged, no error.
- Issue rd = 5 in the same cycle that wb_wr_en_o writes rd = 5 → busy[5] remains 1. With busy[5] = 1, iss_rs2_addr_i = 5 → hazard_o = 1.
- Request rd = 6 with busy[6] = 0 → wb_err_o = 1 the next cycle and it stays 1 until reset.
